// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider.
package div_pkg;

    // Default operand/result width in bits.
    localparam int DIV_WIDTH = 8;

    // Control states: wait for operands, iterate, apply signs, present result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage : div_pkg

// File: rtl/div_seq.sv
// Sequential signed divider. It computes one radix-2 restoring iteration per
// cycle on the operand magnitudes, then applies the signs in a single fix-up
// cycle. The result is held until the consumer takes it.
// The quotient truncates toward zero, and the remainder takes the sign of the
// dividend.
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int                CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]  MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]  ALL_ONES  = {WIDTH{1'b1}};

    // Two's-complement negation, used both for magnitudes and the sign fix.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    // Magnitude of a signed value; -2^(WIDTH-1) maps to 2^(WIDTH-1) unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? negate(x) : x;
    endfunction

    div_state_t       state_q,       state_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;
    logic [WIDTH-1:0] rem_q,         rem_d;          // partial remainder magnitude
    logic [WIDTH-1:0] quo_q,         quo_d;          // dividend bits shifting out, quotient bits in
    logic [WIDTH-1:0] dvs_q,         dvs_d;          // divisor magnitude
    logic [WIDTH-1:0] dvd_q,         dvd_d;          // raw dividend, returned on divide-by-zero
    logic             neg_quo_q,     neg_quo_d;
    logic             neg_rem_q,     neg_rem_d;
    logic             zero_q,        zero_d;
    logic             ovf_q,         ovf_d;
    logic             out_valid_q,   out_valid_d;
    logic [WIDTH-1:0] quotient_q,    quotient_d;
    logic [WIDTH-1:0] remainder_q,   remainder_d;
    logic             div_by_zero_q, div_by_zero_d;
    logic             overflow_q,    overflow_d;

    // One restoring step: shift in the next dividend bit and subtract when it fits.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_q};

    // Next-state and datapath logic for the whole divider.
    always_comb begin
        // NOTE: every _d gets its current value first, so any path that leaves
        // a signal unassigned holds it instead of inferring a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        dvs_d         = dvs_q;
        dvd_d         = dvd_q;
        neg_quo_d     = neg_quo_q;
        neg_rem_d     = neg_rem_q;
        zero_d        = zero_q;
        ovf_d         = ovf_q;
        out_valid_d   = out_valid_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        overflow_d    = overflow_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvd_d     = dividend;
                    quo_d     = magnitude(dividend);
                    dvs_d     = magnitude(divisor);
                    rem_d     = '0;
                    cnt_d     = '0;
                    neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    neg_rem_d = dividend[WIDTH-1];
                    zero_d    = (divisor == '0);
                    ovf_d     = (dividend == MOST_NEG) && (divisor == ALL_ONES);
                    state_d   = CALC;
                end
            end

            CALC: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                if (zero_q) begin
                    quotient_d  = ALL_ONES;
                    remainder_d = dvd_q;
                end else if (ovf_q) begin
                    quotient_d  = MOST_NEG;
                    remainder_d = '0;
                end else begin
                    quotient_d  = neg_quo_q ? negate(quo_q) : quo_q;
                    remainder_d = neg_rem_q ? negate(rem_q) : rem_q;
                end
                div_by_zero_d = zero_q;
                overflow_d    = ovf_q && !zero_q;
                out_valid_d   = 1'b1;
                state_d       = DONE;
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            dvs_q         <= '0;
            dvd_q         <= '0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            zero_q        <= 1'b0;
            ovf_q         <= 1'b0;
            out_valid_q   <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge values computed by the combinational block.
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            dvs_q         <= dvs_d;
            dvd_q         <= dvd_d;
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
            zero_q        <= zero_d;
            ovf_q         <= ovf_d;
            out_valid_q   <= out_valid_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            overflow_q    <= overflow_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;
    assign overflow    = overflow_q;

endmodule : div_seq

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq. It keeps an arithmetic reference model with
// a queue of expected results. Every cycle in which out_valid is high, the DUT
// is compared against that model. Directed cases carry hand-computed literals.
module tb_div_seq;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    div_seq #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dbz;
        logic             ovf;
        int               acc;
        bit               seen;
    } exp_t;

    exp_t exp_q[$];

    // Reference: integer division truncates toward zero, % follows the dividend sign.
    function automatic exp_t model(input logic signed [WIDTH-1:0] a, input logic signed [WIDTH-1:0] b);
        exp_t e;
        int   ai;
        int   bi;
        ai     = a;
        bi     = b;
        e.dbz  = 1'b0;
        e.ovf  = 1'b0;
        e.acc  = 0;
        e.seen = 1'b0;
        if (bi == 0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else if (ai == -(2 ** (WIDTH - 1)) && bi == -1) begin
            e.q   = a;
            e.r   = '0;
            e.ovf = 1'b1;
        end else begin
            e.q = WIDTH'(ai / bi);
            e.r = WIDTH'(ai % bi);
        end
        return e;
    endfunction

    // Monitor and compare: log accepted operations, check every valid result cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (in_valid && in_ready) begin
                e     = model(dividend, divisor);
                e.acc = cyc + 1;
                exp_q.push_back(e);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    check("model_quotient",    32'(quotient),    32'(exp_q[0].q));
                    check("model_remainder",   32'(remainder),   32'(exp_q[0].r));
                    check("model_div_by_zero", 32'(div_by_zero), 32'(exp_q[0].dbz));
                    check("model_overflow",    32'(overflow),    32'(exp_q[0].ovf));
                    if (!exp_q[0].seen) begin
                        check("latency", 32'(cyc - exp_q[0].acc), 32'(WIDTH + 1));
                        exp_q[0].seen = 1'b1;
                    end
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Present one operation and hold it until the divider is ready for it.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #2;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        dividend = WIDTH'($urandom);
        divisor  = WIDTH'($urandom);
    endtask

    task automatic wait_out(output bit got);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
    endtask

    // Directed case with literal expectations, plus a hold check once back in IDLE.
    task automatic run_lit(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                           input logic edbz, input logic eovf);
        bit got;
        do_op(a, b);
        wait_out(got);
        if (got) begin
            check({name, "_quotient"},    32'(quotient),    32'(eq));
            check({name, "_remainder"},   32'(remainder),   32'(er));
            check({name, "_div_by_zero"}, 32'(div_by_zero), 32'(edbz));
            check({name, "_overflow"},    32'(overflow),    32'(eovf));
        end
        wait_idle();
        @(negedge clk);
        check({name, "_idle_out_valid"}, 32'(out_valid), 32'd0);
        check({name, "_idle_hold_q"},    32'(quotient),  32'(eq));
    endtask

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } vec_t;

    initial begin
        vec_t vecs[$];
        bit   got;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;

        // Reset values.
        repeat (2) @(posedge clk);
        #2;
        check("rst_out_valid",   32'(out_valid),   32'd0);
        check("rst_quotient",    32'(quotient),    32'd0);
        check("rst_remainder",   32'(remainder),   32'd0);
        check("rst_div_by_zero", 32'(div_by_zero), 32'd0);
        check("rst_overflow",    32'(overflow),    32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Hand-computed sign and corner cases.
        run_lit("p100_p7",   8'd100,  8'd7,    8'h0E, 8'h02, 1'b0, 1'b0);
        run_lit("n100_p7",   8'h9C,   8'd7,    8'hF2, 8'hFE, 1'b0, 1'b0);
        run_lit("p100_n7",   8'd100,  8'hF9,   8'hF2, 8'h02, 1'b0, 1'b0);
        run_lit("n100_n7",   8'h9C,   8'hF9,   8'h0E, 8'hFE, 1'b0, 1'b0);
        run_lit("p5_zero",   8'd5,    8'd0,    8'hFF, 8'h05, 1'b1, 1'b0);
        run_lit("n128_n1",   8'h80,   8'hFF,   8'h80, 8'h00, 1'b0, 1'b1);
        run_lit("after_flag",8'd9,    8'd4,    8'h02, 8'h01, 1'b0, 1'b0);

        // More operand patterns, checked against the model only.
        vecs = '{'{8'd127, 8'd1},   '{8'h80, 8'd1},   '{8'h80, 8'd2},   '{8'd7, 8'd100},
                 '{8'hFF, 8'd0},    '{8'h80, 8'd0},   '{8'd0, 8'd5},    '{8'h80, 8'h80},
                 '{8'd127, 8'h80},  '{8'hF9, 8'd2},   '{8'd1, 8'hFF},   '{8'd127, 8'd127}};
        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b);
            wait_idle();
        end

        // Stall in DONE for five cycles, then a back-to-back operation.
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        do_op(8'd50, 8'd3);
        wait_out(got);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready",  32'(in_ready),  32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_quotient",  32'(quotient),  32'h10);
            check("stall_remainder", 32'(remainder), 32'h02);
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        dividend  = 8'hCE;   // -50
        divisor   = 8'd3;
        @(negedge clk);
        check("b2b_before_hs_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("b2b_after_hs_in_ready",  32'(in_ready),  32'd1);
        check("b2b_after_hs_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        wait_out(got);
        if (got) begin
            check("b2b_quotient",  32'(quotient),  32'hF0);
            check("b2b_remainder", 32'(remainder), 32'hFE);
        end
        wait_idle();

        // Reset in the middle of CALC: outputs clear at once, no result follows.
        do_op(8'd100, 8'd7);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid",   32'(out_valid),   32'd0);
        check("midrst_quotient",    32'(quotient),    32'd0);
        check("midrst_remainder",   32'(remainder),   32'd0);
        check("midrst_div_by_zero", 32'(div_by_zero), 32'd0);
        check("midrst_overflow",    32'(overflow),    32'd0);
        exp_q.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("midrst_no_out_valid", 32'(out_valid), 32'd0);
        end

        // Normal operation resumes after the abort.
        run_lit("post_rst", 8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_div_seq

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (two's complement).
REQ-002 SHALL have port: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port: in_valid  input  1  dividend/divisor present.
REQ-005 SHALL have port: in_ready  output  1  block can accept an operation.
REQ-006 SHALL have port: dividend  input  WIDTH  signed dividend.
REQ-007 SHALL have port: divisor  input  WIDTH  signed divisor.
REQ-008 SHALL have port: out_valid  output  1  result present.
REQ-009 SHALL have port: out_ready  input  1  consumer takes result.
REQ-010 SHALL have port: quotient  output  WIDTH  signed quotient.
REQ-011 SHALL have port: remainder  output  WIDTH  signed remainder.
REQ-012 SHALL have port: div_by_zero  output  1  result came from a zero divisor.
REQ-013 SHALL have port: overflow  output  1  result came from the most-negative / -1 case.

Function
REQ-014 SHALL be a sequential signed divider, the inverse of the team's signed combinational multiplier; one radix-2 restoring iteration per cycle on operand magnitudes.
REQ-015 SHALL use FSM states IDLE, CALC, FIX, DONE; reset state IDLE.
REQ-016 SHALL drive in_ready high only in IDLE; accept when in_valid && in_ready at a rising edge (edge 0), capturing both operands and going to CALC.
REQ-017 SHALL perform exactly WIDTH iterations in CALC on edges 1..WIDTH, then go to FIX.
REQ-018 SHALL in FIX (edge WIDTH+1) apply sign correction, load the outputs and enter DONE; out_valid is high from edge WIDTH+1, giving a fixed latency of WIDTH+1 cycles (9 for WIDTH=8).
REQ-019 SHALL truncate the quotient toward zero; remainder sign equals dividend sign; dividend = quotient*divisor + remainder.
REQ-020 SHALL on divisor==0 give quotient all-ones, remainder = dividend, div_by_zero=1, with the same latency.
REQ-021 SHALL on dividend==most-negative and divisor==-1 give quotient = most-negative, remainder 0, overflow=1, with the same latency.
REQ-022 SHALL hold out_valid, quotient, remainder and the flags stable in DONE until out_valid && out_ready, then go to IDLE; in_ready rises in the next cycle.
REQ-023 SHALL ignore in_valid outside IDLE; operand inputs are don't-care after acceptance.
REQ-024 SHALL clear div_by_zero and overflow to 0 for normal results.
REQ-025 SHALL keep outputs at their last values in IDLE; out_valid is 0 in IDLE.

Reset
REQ-026 SHALL on rst_n low immediately force state IDLE; in_ready=1 after release; out_valid, quotient, remainder, div_by_zero, overflow = 0; iteration counter and working registers = 0.
REQ-027 SHALL abort any in-progress operation on reset with no result emitted.

Structure
REQ-028 SHALL place the FSM state enum typedef and the default WIDTH constant in shared package div_pkg.
REQ-029 SHALL need no sub-module; the iteration step, magnitude conversion and sign fix stay inline.
REQ-030 SHALL use no vendor arithmetic primitives; iteration counter width is clog2(WIDTH+1).

Verification
REQ-031 SHALL cover: 100 / 7 -> quotient 0x0E, remainder 0x02, flags 0, out_valid exactly 9 cycles after accept.
REQ-032 SHALL cover: -100 / 7 -> 0xF2, 0xFE; 100 / -7 -> 0xF2, 0x02; -100 / -7 -> 0x0E, 0xFE.
REQ-033 SHALL cover: 5 / 0 -> quotient 0xFF, remainder 0x05, div_by_zero 1; -128 / -1 -> quotient 0x80, remainder 0x00, overflow 1.
REQ-034 SHALL cover: out_ready held low 5 cycles in DONE -> outputs stable, in_ready 0; on handshake, a back-to-back in_valid is accepted the following cycle.
REQ-035 SHALL cover: rst_n asserted on edge 4 of CALC -> all outputs 0 immediately, in_ready 1 after release, no out_valid pulse.
